// File: rtl/cascade_tick_divider.sv
// Cascade of synchronous divider stages: stage i counts tick pulses of stage i-1, all on clk.
// Define CASCADE_DIV_RUNTIME_EN to add run-time divisor load ports (div_load/div_sel/div_value).
module cascade_tick_divider #(
    parameter int unsigned STAGES      = 7,
    parameter int unsigned COUNT_W     = 8,
    parameter int unsigned CLOCK_COUNT = 4,
    localparam int unsigned SEL_W      = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
`ifdef CASCADE_DIV_RUNTIME_EN
    input  logic               div_load,
    input  logic [SEL_W-1:0]   div_sel,
    input  logic [COUNT_W-1:0] div_value,
`endif
    output logic [STAGES-1:0]  tick,
    output logic [STAGES-1:0]  level
);

    // Counters hold D-1 as their terminal value, so D = 2^COUNT_W still fits COUNT_W bits.
    localparam logic [COUNT_W-1:0] LastInit = COUNT_W'(CLOCK_COUNT - 1);

    if (STAGES < 1 || CLOCK_COUNT < 1 ||
        longint'(CLOCK_COUNT) > (longint'(1) << COUNT_W) ||
        (longint'(1) << SEL_W) < longint'(STAGES)) begin : g_bad_params
        $error("cascade_tick_divider: illegal parameter combination");
    end

    logic [STAGES-1:0] pulse_in;

    for (genvar i = 0; i < STAGES; i++) begin : g_in
        if (i == 0) begin : g_first
            assign pulse_in[i] = en;
        end else begin : g_next
            assign pulse_in[i] = tick[i-1];
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [COUNT_W-1:0] cnt_q, cnt_d;
        logic [COUNT_W-1:0] last;
        logic               tick_q, tick_d;
        logic               level_q, level_d;
        logic               load;

`ifdef CASCADE_DIV_RUNTIME_EN
        logic [COUNT_W-1:0] last_q, last_d;

        // Out-of-range div_sel matches no stage, so such loads are dropped.
        assign load = div_load && (div_sel == SEL_W'(i));
        assign last = last_q;

        always_comb begin
            last_d = last_q;
            if (load) begin
                last_d = (div_value == '0) ? '0 : div_value - COUNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                last_q <= LastInit;
            end else begin
                last_q <= last_d;
            end
        end
`else
        assign load = 1'b0;
        assign last = LastInit;
`endif

        always_comb begin
            cnt_d   = cnt_q;
            tick_d  = 1'b0;
            level_d = level_q;
            if (load) begin
                cnt_d = '0;
            end else if (pulse_in[i]) begin
                if (cnt_q == last) begin
                    cnt_d   = '0;
                    tick_d  = 1'b1;
                    level_d = ~level_q;
                end else begin
                    cnt_d = cnt_q + COUNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q   <= '0;
                tick_q  <= 1'b0;
                level_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                tick_q  <= tick_d;
                level_q <= level_d;
            end
        end

        assign tick[i]  = tick_q;
        assign level[i] = level_q;
    end

endmodule

// File: doc/cascade_tick_divider.md
# cascade_tick_divider

Parametrised cascade of synchronous divider stages producing single-cycle tick enables and 50%-duty level outputs from one system clock. It replaces the ripple-clocked divider chain: every flop runs on `clk`, and stage *i* counts stage *i-1* ticks. Its outputs feed LED heartbeat logic and the HD44780 controller's timing enables; they are never used as clocks.

## Interface
- `STAGES`, 7: number of cascaded stages, ≥1.
- `COUNT_W`, 8: per-stage counter/divisor width.
- `CLOCK_COUNT`, 4: reset/default divisor per stage, 1 ≤ CLOCK_COUNT ≤ 2^COUNT_W.
- `SEL_W`, derived: max(1, clog2(STAGES)), localparam.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run enable; input pulse of stage 0.
- `tick`  out  STAGES  bit *i*: one-cycle pulse per divisor-many stage-*i* input pulses.
- `level`  out  STAGES  bit *i*: toggles on every `tick[i]`.
- `div_load`  in  1  load strobe (only with macro).
- `div_sel`  in  SEL_W  target stage (only with macro).
- `div_value`  in  COUNT_W  new divisor (only with macro).

## Operation
- Stage input pulse: `in[0] = en`; `in[i] = tick[i-1]` (registered value).
- Per stage: counter `cnt[i]`, divisor `D[i]`.
  - `in[i]` high and `cnt[i] == D[i]-1`: `cnt[i] <= 0`, `tick[i] <= 1`, `level[i] <= ~level[i]`.
  - `in[i]` high otherwise: `cnt[i] <= cnt[i]+1`, `tick[i] <= 0`.
  - `in[i]` low: `cnt[i]` holds, `tick[i] <= 0`.
- `D[i] = 1`: tick on every input pulse; `level` period = 2 input pulses.
- Counter arithmetic is modulo D; it never exceeds D-1 and never wraps through 2^COUNT_W.
- `en` low freezes stage 0; ticks already registered still propagate one stage per cycle, then the chain is quiescent. Counters are retained; no phase loss on re-enable.
- Reset: `cnt` = 0, `tick` = 0, `level` = 0, `D[i]` = CLOCK_COUNT. Reset mid-count discards all in-flight pulses the same cycle.

## Timing
- `tick`/`level` are registered; each stage adds 1 cycle of latency.
- With `en` held high from the first edge after `rst` falls (that edge = edge 1) and uniform divisor D: first `tick[i]` is high after edge D^(i+1)+i, period D^(i+1) cycles.
- `tick[i]` is never high for two consecutive cycles when D[i] ≥ 2 or when the input is single-cycle.
- `level[i]` changes on exactly the same edge that raises `tick[i]`.

## Configuration
- `CASCADE_DIV_RUNTIME_EN` defined: ports `div_load`, `div_sel`, `div_value` exist and `D[i]` is a register.
  - `div_load` high at an edge: `D[div_sel] <= (div_value == 0) ? 1 : div_value`, `cnt[div_sel] <= 0`, `tick[div_sel] <= 0` that edge; load overrides counting for that stage only. `level` holds.
  - `div_sel ≥ STAGES`: load ignored.
  - `rst` overrides `div_load`.
- Not defined: the three ports are absent; `D[i]` is constant CLOCK_COUNT; no divisor registers are inferred.

## Test plan
- STAGES=3, D=4, `en`=1 after reset: first `tick[0]`/`tick[1]`/`tick[2]` high after edges 4/17/66; `tick[0]` period 4, `level[0]` period 8.
- Drop `en` for 10 cycles at `cnt[0]`=2: no new `tick[0]`; after re-enable next `tick[0]` 2 enabled cycles later; pending `tick[1]` still fires once.
- Assert `rst` one cycle while `tick[1]` is high: next cycle all `tick`, `level`, `cnt` = 0; restart timing matches first test.
- Macro on: load stage 0 with `div_value`=0: stored D=1, `tick[0]` high every cycle with `en`=1, `level[0]` toggles every cycle.
- Macro on: load stage 1 with 2 while `cnt[1]`=3 and `tick[0]` high the same edge: `cnt[1]` = 0, no `tick[1]`; thereafter `tick[1]` on every 2nd `tick[0]`.
- Macro on: `div_sel`=3 with STAGES=3: no divisor, counter or output changes.
